// File: rtl/video_gen.sv
// -----------------------------------------------------------------------------
// video_gen
//
// Character-mode video generator for a 40x25 text display. It follows the bus
// timing generator's slot strobes. It drives the video RAM address, then the
// character ROM address. It captures the returned bytes from the shared data
// bus and shifts the glyph row out as a 1-bit pixel stream. Horizontal and
// vertical sync are generated alongside the pixel stream.
//
// Slot sequence (16 cycles):
//   RAM strobe (2 cycles) -> char_q captured on the 2nd cycle
//   ROM strobe (2 cycles) -> glyph row loaded on the 2nd cycle, slot ends
//   8 pixels, each held 2 cycles, until the next ROM capture
//
// Ports:
//   clk_16_i            16 MHz clock (only clock)
//   reset_n_i           asynchronous active-low reset
//   video_ram_enable_i  video RAM slot strobe (2 cycles every 16)
//   video_rom_enable_i  character ROM slot strobe (2 cycles after RAM strobe)
//   pixel_ce_i          pixel clock enable, every second cycle
//   gfx_i               character set select (ROM address MSB)
//   bus_data_i[7:0]     shared data bus
//   ram_addr_o[9:0]     video RAM address (row_base + h_count)
//   rom_addr_o[10:0]    character ROM address {gfx, char[6:0], scanline}
//   video_o             pixel output, 1 = lit
//   display_en_o        current 8-pixel slot is in the visible area
//   hsync_o / vsync_o   active-high sync pulses
// -----------------------------------------------------------------------------
module video_gen #(
  parameter int COLS        = 40,
  parameter int ROWS        = 25,
  parameter int H_TOTAL     = 64,
  parameter int HSYNC_START = 48,
  parameter int HSYNC_WIDTH = 4,
  parameter int V_TOTAL     = 260,
  parameter int VSYNC_START = 220,
  parameter int VSYNC_WIDTH = 4
) (
  input  logic        clk_16_i,
  input  logic        reset_n_i,
  input  logic        video_ram_enable_i,
  input  logic        video_rom_enable_i,
  input  logic        pixel_ce_i,
  input  logic        gfx_i,
  input  logic [7:0]  bus_data_i,
  output logic [9:0]  ram_addr_o,
  output logic [10:0] rom_addr_o,
  output logic        video_o,
  output logic        display_en_o,
  output logic        hsync_o,
  output logic        vsync_o
);

  localparam int HW        = $clog2(H_TOTAL);
  localparam int VW        = $clog2(V_TOTAL);
  localparam int VIS_LINES = ROWS * 8;

  // State registers
  logic          ram_en_prev_q, ram_en_prev_d;
  logic          rom_en_prev_q, rom_en_prev_d;
  logic [7:0]    char_q, char_d;
  logic [7:0]    shift_q, shift_d;
  logic [HW-1:0] h_count_q, h_count_d;
  logic [VW-1:0] v_count_q, v_count_d;
  logic [9:0]    row_base_q, row_base_d;
  logic          display_en_q, display_en_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;

  logic          ram_cap;
  logic          rom_cap;
  logic [7:0]    load_pattern;

  // Bit 7 of the character code inverts the whole glyph row (reverse video).
  for (genvar gi = 0; gi < 8; gi++) begin : g_load
    assign load_pattern[gi] = bus_data_i[gi] ^ char_q[7];
  end

  always_comb begin
    // Capture fires on the second (and any later) consecutive strobe cycle,
    // so a single-cycle glitch on a strobe never captures.
    ram_cap = video_ram_enable_i & ram_en_prev_q;
    rom_cap = video_rom_enable_i & rom_en_prev_q;

    ram_en_prev_d = video_ram_enable_i;
    rom_en_prev_d = video_rom_enable_i;
    char_d        = char_q;
    shift_d       = shift_q;
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    row_base_d    = row_base_q;
    display_en_d  = display_en_q;

    if (ram_cap) begin
      char_d = bus_data_i;
    end

    // Loading a new glyph row wins over shifting on the same cycle.
    if (rom_cap) begin
      shift_d = load_pattern;
    end else if (pixel_ce_i) begin
      shift_d = {shift_q[6:0], 1'b0};
    end

    // The slot ends on ROM capture: visibility is latched for the slot just
    // fetched, then the horizontal position advances.
    if (rom_cap) begin
      display_en_d = (int'(h_count_q) < COLS) && (int'(v_count_q) < VIS_LINES);
      if (int'(h_count_q) == H_TOTAL - 1) begin
        h_count_d = '0;
        if (int'(v_count_q) == V_TOTAL - 1) begin
          v_count_d  = '0;
          row_base_d = '0;
        end else begin
          v_count_d = v_count_q + VW'(1);
          // Last scanline of a visible character row: step to the next row
          // of the screen buffer.
          if (v_count_q[2:0] == 3'd7 && int'(v_count_q) < VIS_LINES) begin
            row_base_d = row_base_q + 10'(COLS);
          end
        end
      end else begin
        h_count_d = h_count_q + HW'(1);
      end
    end

    // Sync flags are decoded from the next counter values so that the
    // registered flags always match the registered counters.
    hsync_d = (int'(h_count_d) >= HSYNC_START) &&
              (int'(h_count_d) <  HSYNC_START + HSYNC_WIDTH);
    vsync_d = (int'(v_count_d) >= VSYNC_START) &&
              (int'(v_count_d) <  VSYNC_START + VSYNC_WIDTH);
  end

  always_ff @(posedge clk_16_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ram_en_prev_q <= 1'b0;
      rom_en_prev_q <= 1'b0;
      char_q        <= '0;
      shift_q       <= '0;
      h_count_q     <= '0;
      v_count_q     <= '0;
      row_base_q    <= '0;
      display_en_q  <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
    end else begin
      ram_en_prev_q <= ram_en_prev_d;
      rom_en_prev_q <= rom_en_prev_d;
      char_q        <= char_d;
      shift_q       <= shift_d;
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      row_base_q    <= row_base_d;
      display_en_q  <= display_en_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

  // Fetches during blanking still go out; their data is simply never shown.
  assign ram_addr_o   = row_base_q + 10'(h_count_q);
  assign rom_addr_o   = {gfx_i, char_q[6:0], v_count_q[2:0]};
  assign video_o      = shift_q[7] & display_en_q;
  assign display_en_o = display_en_q;
  assign hsync_o      = hsync_q;
  assign vsync_o      = vsync_q;

endmodule

// File: tb/tb_video_gen.sv
// -----------------------------------------------------------------------------
// tb_video_gen
//
// Drives the slot strobes with the upstream 16-cycle pattern, serves random
// video RAM / character ROM contents, and compares the generator's outputs
// with a reference model built from screen geometry (line, slot, row).
// The line length is shortened so a whole frame stays brief.
// -----------------------------------------------------------------------------
module tb_video_gen;

  localparam int COLS        = 12;
  localparam int ROWS        = 25;
  localparam int H_TOTAL     = 16;
  localparam int HSYNC_START = 13;
  localparam int HSYNC_WIDTH = 2;
  localparam int V_TOTAL     = 260;
  localparam int VSYNC_START = 220;
  localparam int VSYNC_WIDTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ram_en = 1'b0;
  logic        rom_en = 1'b0;
  logic        pce = 1'b0;
  logic        gfx = 1'b0;
  logic [7:0]  bus = 8'h00;
  logic [9:0]  ram_addr;
  logic [10:0] rom_addr;
  logic        video;
  logic        disp_en;
  logic        hsync;
  logic        vsync;

  video_gen #(
    .COLS(COLS), .ROWS(ROWS), .H_TOTAL(H_TOTAL),
    .HSYNC_START(HSYNC_START), .HSYNC_WIDTH(HSYNC_WIDTH),
    .V_TOTAL(V_TOTAL), .VSYNC_START(VSYNC_START), .VSYNC_WIDTH(VSYNC_WIDTH)
  ) dut (
    .clk_16_i(clk),
    .reset_n_i(rst_n),
    .video_ram_enable_i(ram_en),
    .video_rom_enable_i(rom_en),
    .pixel_ce_i(pce),
    .gfx_i(gfx),
    .bus_data_i(bus),
    .ram_addr_o(ram_addr),
    .rom_addr_o(rom_addr),
    .video_o(video),
    .display_en_o(disp_en),
    .hsync_o(hsync),
    .vsync_o(vsync)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents served on the bus
  logic [7:0] vram [1024];
  logic [7:0] crom [2048];

  // Reference model: screen position and the glyph row currently on screen
  int         m_line;
  int         m_slot;
  logic [7:0] m_char;
  logic [7:0] pix_pat;
  logic       pix_disp;
  bit         first_frame;

  // Completed character rows times row width; below the visible area the
  // base stays at the value reached after the last visible row.
  function automatic int row_base(input int line);
    int rows_done;
    rows_done = (line < ROWS * 8) ? line / 8 : ROWS;
    return (rows_done * COLS) % 1024;
  endfunction

  function automatic int exp_rom();
    return (int'(gfx) << 10) | (int'(m_char & 8'h7F) << 3) | (m_line % 8);
  endfunction

  task automatic model_clear();
    m_line   = 0;
    m_slot   = 0;
    m_char   = 8'h00;
    pix_pat  = 8'h00;
    pix_disp = 1'b0;
  endtask

  // One clock cycle at slot phase p (0..15). Inputs change at the falling
  // edge, outputs are sampled 1 ns later, the DUT sees inputs at the rise.
  task automatic run_cycle(input int p, input bit skip_ram);
    int ea;
    int k;
    @(negedge clk);
    ea     = (row_base(m_line) + m_slot) % 1024;
    ram_en = (p < 2) && !skip_ram;
    rom_en = (p == 2) || (p == 3);
    pce    = (p % 2) == 1;
    if (p < 2)      bus = vram[ea];
    else if (p < 4) bus = crom[exp_rom()];
    else            bus = 8'($urandom);
    #1;
    // Pixel k of the row on screen; the row changes between phase 3 and 4.
    k = ((p + 12) % 16) / 2;
    check_val("video_o", video, pix_disp & pix_pat[7 - k]);
    if (p == 0) begin
      check_val("ram_addr", ram_addr, ea);
      check_val("display_en", disp_en, pix_disp);
      check_val("hsync", hsync, (m_slot >= HSYNC_START) && (m_slot < HSYNC_START + HSYNC_WIDTH));
      check_val("vsync", vsync, (m_line >= VSYNC_START) && (m_line < VSYNC_START + VSYNC_WIDTH));
    end
    if (p == 2) check_val("rom_addr", rom_addr, exp_rom());
    if (p == 1 && !skip_ram) m_char = vram[ea];
    if (p == 3) begin
      pix_pat  = crom[exp_rom()] ^ {8{m_char[7]}};
      pix_disp = (m_slot < COLS) && (m_line < ROWS * 8);
      m_slot++;
      if (m_slot == H_TOTAL) begin
        m_slot = 0;
        m_line = (m_line + 1) % V_TOTAL;
      end
    end
  endtask

  task automatic run_slot();
    bit directed;
    bit skip;
    directed = first_frame && m_line == 0 && m_slot < 2;
    skip     = !directed && ($urandom_range(0, 15) == 0);
    gfx      = directed ? 1'b0 : 1'($urandom_range(0, 1));
    for (int p = 0; p < 16; p++) run_cycle(p, skip);
  endtask

  task automatic run_line();
    int line;
    line = m_line;
    for (int s = 0; s < H_TOTAL; s++) run_slot();
    $display("line %0d: base=%0d checks=%0d errors=%0d", line, row_base(line), n_checks, n_errors);
  endtask

  task automatic check_reset_state(input string phase);
    check_val({phase, " ram_addr"}, ram_addr, 0);
    check_val({phase, " rom_addr"}, rom_addr, int'(gfx) << 10);
    check_val({phase, " video_o"}, video, 0);
    check_val({phase, " display_en"}, disp_en, 0);
    check_val({phase, " hsync"}, hsync, 0);
    check_val({phase, " vsync"}, vsync, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) vram[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) crom[i] = 8'($urandom);
    vram[0]     = 8'h01;   // plain glyph 1, slot 0
    vram[1]     = 8'h81;   // same glyph reversed, slot 1
    crom[11'h008] = 8'hA5; // glyph 1, scanline 0, set 0

    // Power-on reset
    repeat (3) @(negedge clk);
    #1;
    check_reset_state("por");
    $display("power-on reset released");
    rst_n = 1'b1;

    // One full frame plus two lines into the next
    model_clear();
    first_frame = 1'b1;
    for (int l = 0; l < V_TOTAL; l++) run_line();
    first_frame = 1'b0;
    for (int l = 0; l < 2; l++) run_line();

    // Asynchronous reset in the middle of a slot with nonzero counters
    for (int p = 0; p < 6; p++) run_cycle(p, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid-slot reset");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ram_en = (i % 16) < 2;
      rom_en = (i % 16) == 2 || (i % 16) == 3;
      pce    = (i % 2) == 1;
      bus    = 8'($urandom);
      gfx    = 1'($urandom_range(0, 1));
      #1;
      check_reset_state("held reset");
    end
    @(negedge clk);
    ram_en = 1'b0;
    rom_en = 1'b0;
    rst_n  = 1'b1;
    $display("mid-slot reset released");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pce = (i % 2) == 1;
      #1;
      check_reset_state("idle");
    end

    // Single-cycle strobe pulses must not capture anything
    @(negedge clk);
    ram_en = 1'b1;
    bus    = 8'h7F;
    @(negedge clk);
    ram_en = 1'b0;
    rom_en = 1'b1;
    bus    = 8'hFF;
    @(negedge clk);
    rom_en = 1'b0;
    bus    = 8'h00;
    #1;
    check_reset_state("pulse");
    $display("single-cycle strobe pulses applied");

    // Resume normal slots from a cleared state
    model_clear();
    for (int l = 0; l < 2; l++) run_line();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
